board_controller: RTL and testbench
===================================

Name: board_controller

Overview:
- Game-state stage directly upstream of the renderer, in the 25 MHz pixel-clock domain.
- Debounces five push-buttons, sampled once per video frame.
- Moves a cursor over a fixed 3x3 tic-tac-toe grid and places X/O marks on select.
- Detects win/draw and drives player_address, the board contents and the game status into the renderer.

Parameters:
- DEBOUNCE_FRAMES, 3: consecutive frame samples a raw button level must hold before the debounced level changes (legal range 1..15).
- BTN_ACTIVE_LOW, 1: 1 means the raw button inputs are low when pressed (board keys); 0 means high when pressed.

Ports:
- clk  input  1  pixel clock (25 MHz, same clock as synchronizer and renderer).
- rst  input  1  asynchronous active-low reset.
- vsync  input  1  vertical sync from synchronizer, active low; its falling edge defines the frame tick.
- btn_up, btn_down, btn_left, btn_right, btn_select  input  1 each  raw asynchronous buttons.
- player_address  output  4  cursor cell index = row*3+col, range 0..8.
- board  output  18  cell i occupies bits [2i+1:2i]; 00 empty, 01 X, 10 O.
- turn  output  1  0 = X to move, 1 = O to move.
- game_over  output  1  high while in OVER.
- winner  output  2  00 none, 01 X, 10 O, 11 draw.

Behaviour:
- Reset (rst=0, async): state=PLAY, player_address=0, board=0, turn=0, game_over=0, winner=00; all debouncers cleared to "released".
- Input path: each button passes a 2-flop synchronizer, then polarity is normalised so 1=pressed.
- Frame tick: one-cycle pulse on the clk cycle after the registered vsync goes 1->0. Exactly one tick per frame.
- Debounce, evaluated only on a tick:
  - If the sampled level differs from the debounced level, increment a counter; otherwise clear it.
  - When the counter reaches DEBOUNCE_FRAMES, the debounced level takes the sampled value and the counter clears.
  - A press event is a debounced 0->1 transition.
- Event priority: at most one event is acted on per tick, in the order select > up > down > left > right. Lower-priority events in the same tick are dropped.
- Cursor movement (PLAY only): row/col wrap within the grid.
  - up: row 0 -> row 2. down: row 2 -> row 0.
  - left: col 0 -> col 2. right: col 2 -> col 0.
  - The other coordinate is unchanged; player_address updates on the cycle after the tick.
- States:
  - PLAY:
    - select on an empty cell: write mark (turn ? O : X) into that cell, go to CHECK.
    - select on an occupied cell: ignored, stay in PLAY.
  - CHECK (exactly 1 cycle):
    - If any of the 8 win lines holds three equal non-empty marks: winner = that mark, game_over=1, go to OVER.
    - Else if all 9 cells are non-empty: winner=11, game_over=1, go to OVER.
    - Else: toggle turn, return to PLAY.
  - OVER:
    - Direction events are ignored.
    - select: board=0, turn=0, winner=00, game_over=0, player_address=0, go to PLAY.
- Latency: select tick -> board write is 1 cycle; winner/game_over are valid 2 cycles after the tick.
- Outputs are registered, and board is stable for the rest of the frame.
- Reset mid-frame or mid-CHECK: the async clear takes effect immediately, with no partial update.
- A button held across a reset produces no press event until it has been released and pressed again, because the debounced level first settles to "pressed" silently from the reset state.
- vsync stuck at either level: no ticks, so the state is frozen.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined: while a direction button stays debounced-pressed, it generates a repeat event every 15 ticks after the initial press (the count is the shared constant REPEAT_FRAMES). Releasing the button or a higher-priority event resets the repeat counter. Select never repeats.
- Undefined: only the edge events described above; no repeat counters are synthesised.

Decomposition:
- Package board_pkg holds:
  - cell_t (EMPTY=2'b00, MARK_X=2'b01, MARK_O=2'b10).
  - winner codes (NONE, WIN_X, WIN_O, DRAW).
  - state enum (PLAY, CHECK, OVER).
  - constants GRID_W=3, GRID_H=3, NUM_CELLS=9, REPEAT_FRAMES=15.
  - WIN_LINES table: 8 entries of 3 cell indices.
- Sub-module button_debouncer (synchronizer + frame-tick debounce + press pulse), instantiated five times.

Test Plan:
- Reset with DEBOUNCE_FRAMES=3 -> all outputs 0. Press btn_right for 3 frames -> player_address=1. Four more presses -> 2, then 0 (wrap), then 1, 2.
- From 0: btn_up -> 6; btn_left -> 8.
- Hold a press for only 2 frames (glitch) -> no movement.
- X plays cells 0,1,2 while O plays 3,4 -> after X's third select, winner=01 and game_over=1 two cycles after the tick. Direction presses are then ignored; select -> board=0, turn=0, address=0.
- Select on an occupied cell 4 -> board unchanged, turn unchanged.
- Fill the board X0,O1,X2,O4,X3,O5,X7,O6,X8 (no line) -> winner=11.
- Same tick with select and right both pressed -> only the mark is placed, cursor unchanged.
- Assert rst mid-game -> immediate clear.
- With AUTO_REPEAT_EN: hold right for 40 frames after debounce -> address advances at frames 0, 15, 30 after the press.

Source files
------------

// File: rtl/board_pkg.sv
// board_pkg: shared types, constants and helpers for the tic-tac-toe board controller
// Contents: cell_t, winner_t, state_t, grid constants, WIN_LINES, cell_at(), move_cursor()
package board_pkg;
   typedef enum logic [1:0] {EMPTY = 2'b00, MARK_X = 2'b01, MARK_O = 2'b10} cell_t;
   typedef enum logic [1:0] {NONE = 2'b00, WIN_X = 2'b01, WIN_O = 2'b10, DRAW = 2'b11} winner_t;
   typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;
   localparam int GRID_W = 3;
   localparam int GRID_H = 3;
   localparam int NUM_CELLS = 9;
   localparam int REPEAT_FRAMES = 15;
   localparam logic [3:0] WIN_LINES [8][3] = '{
      '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}};
   function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
      return b[{i, 1'b0} +: 2];
   endfunction
   // dir: 0 up, 1 down, 2 left, 3 right; both coordinates wrap inside the grid
   function automatic logic [3:0] move_cursor(input logic [3:0] a, input logic [1:0] dir);
      logic [3:0] c;
      c = a % 4'(GRID_W);
      return dir == 2'd0 ? (a < 4'(GRID_W) ? a + 4'(GRID_W * (GRID_H - 1)) : a - 4'(GRID_W)) :
             dir == 2'd1 ? (a >= 4'(GRID_W * (GRID_H - 1)) ? a - 4'(GRID_W * (GRID_H - 1)) : a + 4'(GRID_W)) :
             dir == 2'd2 ? (c == 4'd0 ? a + 4'(GRID_W - 1) : a - 4'd1) :
                           (c == 4'(GRID_W - 1) ? a - 4'(GRID_W - 1) : a + 4'd1);
   endfunction
endpackage

// File: rtl/board_controller_if.sv
// board_controller_if: renderer-facing bundle of the board controller
// Inputs to controller: vsync (active low), btn_up/down/left/right/select (raw)
// Outputs from controller: player_address[3:0], board[17:0], turn, game_over, winner[1:0]
interface board_controller_if;
   logic        vsync;
   logic        btn_up;
   logic        btn_down;
   logic        btn_left;
   logic        btn_right;
   logic        btn_select;
   logic [3:0]  player_address;
   logic [17:0] board;
   logic        turn;
   logic        game_over;
   logic [1:0]  winner;
   modport master (output vsync, btn_up, btn_down, btn_left, btn_right, btn_select,
                   input player_address, board, turn, game_over, winner);
   modport slave (input vsync, btn_up, btn_down, btn_left, btn_right, btn_select,
                  output player_address, board, turn, game_over, winner);
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer, frame-tick debounce and press pulse for one button
// Ports: clk, rst (async active low), i_tick (frame tick), i_btn (raw button),
//        o_level (debounced, 1 = pressed), o_press (one-cycle press event, coincident with i_tick)
module button_debouncer #(
   parameter int unsigned DEBOUNCE_FRAMES = 3,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_tick,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);
   logic [1:0] r_sync;
   logic [3:0] r_cnt;
   logic       r_level;
   logic       r_armed;
   logic       w_pressed;
   logic       w_differ;
   logic       w_settle;
   assign w_pressed = r_sync[1] ^ BTN_ACTIVE_LOW;
   assign w_differ  = w_pressed != r_level;
   assign w_settle  = i_tick & w_differ & (r_cnt == 4'(DEBOUNCE_FRAMES - 1));
   // armed only once a released level has been sampled, so a key held through reset settles silently
   assign o_press   = w_settle & w_pressed & r_armed;
   assign o_level   = r_level;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_sync  <= {2{BTN_ACTIVE_LOW}};
         r_cnt   <= 4'd0;
         r_level <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_btn};
         if (i_tick) begin
            r_cnt <= (w_differ && !w_settle) ? r_cnt + 4'd1 : 4'd0;
            if (w_settle) r_level <= w_pressed;
            if (!w_pressed) r_armed <= 1'b1;
         end
      end
endmodule

// File: rtl/board_controller.sv
// board_controller: tic-tac-toe game state (cursor, marks, win/draw) driven by debounced buttons
// Ports: clk (pixel clock), rst (async active low), bus (board_controller_if.slave)
// Optional: define AUTO_REPEAT_EN for held-direction auto-repeat every REPEAT_FRAMES ticks
module board_controller
   import board_pkg::*;
#(
   parameter int unsigned DEBOUNCE_FRAMES = 3,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input logic               clk,
   input logic               rst,
   board_controller_if.slave bus
);
   logic        r_vs;
   logic        r_vs_d;
   logic        w_tick;
   logic [4:0]  w_raw;
   logic [4:0]  w_level;
   logic [4:0]  w_press;
   logic [4:0]  w_evt;
   state_t      r_state;
   logic [3:0]  r_addr;
   logic [17:0] r_board;
   logic        r_turn;
   logic        r_over;
   winner_t     r_winner;
   logic [1:0]  w_win;
   logic        w_full;
   assign w_tick = r_vs_d & ~r_vs;
   // bit order gives event priority: select, up, down, left, right
   assign w_raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up, bus.btn_select};
   for (genvar b = 0; b < 5; b++) begin : g_btn
      button_debouncer #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_deb (
         .clk(clk), .rst(rst), .i_tick(w_tick), .i_btn(w_raw[b]),
         .o_level(w_level[b]), .o_press(w_press[b]));
   end
`ifdef AUTO_REPEAT_EN
   logic [3:0] w_fire;
   for (genvar d = 0; d < 4; d++) begin : g_rep
      logic [3:0] r_rep;
      assign w_fire[d] = w_tick & w_level[d+1] & (r_rep == 4'(REPEAT_FRAMES - 1));
      // restarts on release, on its own repeat and whenever a higher-priority event wins the tick
      always_ff @(posedge clk or negedge rst)
         if (!rst) r_rep <= 4'd0;
         else if (!w_level[d+1]) r_rep <= 4'd0;
         else if (w_tick) r_rep <= (w_fire[d] || |w_evt[d:0]) ? 4'd0 : r_rep + 4'd1;
   end
   assign w_evt = {w_press[4:1] | w_fire, w_press[0]};
`else
   assign w_evt = w_press;
`endif
   always_comb begin
      w_win  = EMPTY;
      w_full = 1'b1;
      for (int i = 0; i < NUM_CELLS; i++)
         if (cell_at(r_board, 4'(i)) == EMPTY) w_full = 1'b0;
      for (int l = 0; l < 8; l++)
         if (cell_at(r_board, WIN_LINES[l][0]) != EMPTY &&
             cell_at(r_board, WIN_LINES[l][1]) == cell_at(r_board, WIN_LINES[l][0]) &&
             cell_at(r_board, WIN_LINES[l][2]) == cell_at(r_board, WIN_LINES[l][0]))
            w_win = cell_at(r_board, WIN_LINES[l][0]);
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_vs   <= 1'b1;
         r_vs_d <= 1'b1;
      end else begin
         r_vs   <= bus.vsync;
         r_vs_d <= r_vs;
      end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state  <= PLAY;
         r_addr   <= '0;
         r_board  <= '0;
         r_turn   <= 1'b0;
         r_over   <= 1'b0;
         r_winner <= NONE;
      end else begin
         case (r_state)
            PLAY:
               if (w_evt[0]) begin
                  if (cell_at(r_board, r_addr) == EMPTY) begin
                     r_board[{r_addr, 1'b0} +: 2] <= r_turn ? MARK_O : MARK_X;
                     r_state <= CHECK;
                  end
               end else if (|w_evt[4:1])
                  r_addr <= move_cursor(r_addr, w_evt[1] ? 2'd0 : w_evt[2] ? 2'd1 : w_evt[3] ? 2'd2 : 2'd3);
            CHECK:
               if (w_win != EMPTY || w_full) begin
                  r_winner <= w_win != EMPTY ? winner_t'(w_win) : DRAW;
                  r_over   <= 1'b1;
                  r_state  <= OVER;
               end else begin
                  r_turn  <= ~r_turn;
                  r_state <= PLAY;
               end
            OVER:
               if (w_evt[0]) begin
                  r_board  <= '0;
                  r_turn   <= 1'b0;
                  r_winner <= NONE;
                  r_over   <= 1'b0;
                  r_addr   <= '0;
                  r_state  <= PLAY;
               end
            default: r_state <= PLAY;
         endcase
      end
   assign bus.player_address = r_addr;
   assign bus.board          = r_board;
   assign bus.turn           = r_turn;
   assign bus.game_over      = r_over;
   assign bus.winner         = r_winner;
endmodule

// File: tb/tb_board_controller.sv
// tb_board_controller: directed self-checking bench for board_controller (DEBOUNCE_FRAMES=3, active-low keys)
module tb_board_controller;
   localparam logic [4:0] B_S = 5'b00001;
   localparam logic [4:0] B_U = 5'b00010;
   localparam logic [4:0] B_D = 5'b00100;
   localparam logic [4:0] B_L = 5'b01000;
   localparam logic [4:0] B_R = 5'b10000;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   board_controller_if bus();
   board_controller dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic set_btn(input logic [4:0] m);
      bus.btn_select = ~m[0];
      bus.btn_up     = ~m[1];
      bus.btn_down   = ~m[2];
      bus.btn_left   = ~m[3];
      bus.btn_right  = ~m[4];
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         @(negedge clk) bus.vsync = 1'b0;
         repeat (2) @(negedge clk);
         bus.vsync = 1'b1;
         repeat (6) @(negedge clk);
      end
   endtask

   task automatic press(input logic [4:0] m);
      set_btn(m);
      repeat (4) @(negedge clk);
      frames(3);
      set_btn(5'b0);
      repeat (4) @(negedge clk);
      frames(3);
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      frames(1);
   endtask

   task automatic test_reset();
      set_btn(5'b0);
      bus.vsync = 1'b1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.player_address !== 4'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", bus.player_address); end
      n_cmp++; if (bus.board !== 18'h0) begin n_err++; $display("FAIL reset_board got %h want 0", bus.board); end
      n_cmp++; if (bus.turn !== 1'b0) begin n_err++; $display("FAIL reset_turn got %b want 0", bus.turn); end
      n_cmp++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL reset_over got %b want 0", bus.game_over); end
      n_cmp++; if (bus.winner !== 2'b00) begin n_err++; $display("FAIL reset_winner got %b want 00", bus.winner); end
      rst = 1'b1;
      frames(1);
   endtask

   task automatic test_move();
      logic [4:0] m [8];
      logic [3:0] e [8];
      m = '{B_R, B_R, B_R, B_R, B_R, B_R, B_U, B_L};
      e = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd6, 4'd8};
      for (int i = 0; i < 8; i++) begin
         press(m[i]);
         n_cmp++; if (bus.player_address !== e[i]) begin n_err++; $display("FAIL move_%0d got %0d want %0d", i, bus.player_address, e[i]); end
      end
   endtask

   task automatic test_glitch();
      set_btn(B_R);
      repeat (4) @(negedge clk);
      frames(2);
      set_btn(5'b0);
      repeat (4) @(negedge clk);
      frames(4);
      n_cmp++; if (bus.player_address !== 4'd8) begin n_err++; $display("FAIL glitch_addr got %0d want 8", bus.player_address); end
   endtask

   task automatic test_win();
      logic [4:0] m [10];
      logic [3:0] e [10];
      bit found;
      do_reset();
      m = '{B_S, B_D, B_S, B_U, B_R, B_S, B_D, B_S, B_U, B_R};
      e = '{4'd0, 4'd3, 4'd3, 4'd0, 4'd1, 4'd1, 4'd4, 4'd4, 4'd1, 4'd2};
      for (int i = 0; i < 10; i++) begin
         press(m[i]);
         n_cmp++; if (bus.player_address !== e[i]) begin n_err++; $display("FAIL win_path_%0d got %0d want %0d", i, bus.player_address, e[i]); end
      end
      n_cmp++; if (bus.board !== 18'h00285) begin n_err++; $display("FAIL win_pre_board got %h want 00285", bus.board); end
      set_btn(B_S);
      repeat (4) @(negedge clk);
      frames(2);
      @(negedge clk) bus.vsync = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (bus.board !== 18'h00285) found = 1'b1;
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL win_write got no board write within 10 cycles"); end
      n_cmp++; if (bus.game_over !== 1'b0) begin n_err++; $display("FAIL win_over_early got %b want 0", bus.game_over); end
      @(negedge clk);
      n_cmp++; if (bus.game_over !== 1'b1) begin n_err++; $display("FAIL win_over got %b want 1", bus.game_over); end
      n_cmp++; if (bus.winner !== 2'b01) begin n_err++; $display("FAIL win_winner got %b want 01", bus.winner); end
      n_cmp++; if (bus.board !== 18'h00295) begin n_err++; $display("FAIL win_board got %h want 00295", bus.board); end
      bus.vsync = 1'b1;
      repeat (6) @(negedge clk);
      set_btn(5'b0);
      repeat (4) @(negedge clk);
      frames(3);
      n_cmp++; if (bus.turn !== 1'b0) begin n_err++; $display("FAIL win_turn got %b want 0", bus.turn); end
      press(B_U);
      n_cmp++; if (bus.player_address !== 4'd2) begin n_err++; $display("FAIL over_dir got %0d want 2", bus.player_address); end
      press(B_S);
      n_cmp++; if (bus.board !== 18'h0) begin n_err++; $display("FAIL restart_board got %h want 0", bus.board); end
      n_cmp++; if (bus.player_address !== 4'd0) begin n_err++; $display("FAIL restart_addr got %0d want 0", bus.player_address); end
      n_cmp++; if ({bus.turn, bus.game_over, bus.winner} !== 4'b0) begin n_err++; $display("FAIL restart_status got %b want 0000", {bus.turn, bus.game_over, bus.winner}); end
   endtask

   task automatic test_occupied();
      press(B_D);
      press(B_R);
      press(B_S);
      n_cmp++; if (bus.board !== 18'h00100 || bus.turn !== 1'b1) begin n_err++; $display("FAIL occ_first got board %h turn %b want 00100 1", bus.board, bus.turn); end
      press(B_S);
      n_cmp++; if (bus.board !== 18'h00100 || bus.turn !== 1'b1) begin n_err++; $display("FAIL occ_again got board %h turn %b want 00100 1", bus.board, bus.turn); end
   endtask

   task automatic test_draw();
      logic [4:0] m [21];
      logic [3:0] e [21];
      do_reset();
      m = '{B_S, B_R, B_S, B_R, B_S, B_D, B_L, B_S, B_L, B_S, B_R, B_R, B_S, B_D, B_L, B_S, B_L, B_S, B_R, B_R, B_S};
      e = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd4, 4'd4, 4'd3, 4'd3, 4'd4, 4'd5, 4'd5, 4'd8, 4'd7, 4'd7, 4'd6, 4'd6, 4'd7, 4'd8, 4'd8};
      for (int i = 0; i < 21; i++) begin
         press(m[i]);
         n_cmp++; if (bus.player_address !== e[i]) begin n_err++; $display("FAIL draw_path_%0d got %0d want %0d", i, bus.player_address, e[i]); end
      end
      n_cmp++; if (bus.board !== 18'h16A59) begin n_err++; $display("FAIL draw_board got %h want 16a59", bus.board); end
      n_cmp++; if (bus.winner !== 2'b11 || bus.game_over !== 1'b1) begin n_err++; $display("FAIL draw_status got winner %b over %b want 11 1", bus.winner, bus.game_over); end
   endtask

   task automatic test_same_tick();
      do_reset();
      press(B_S | B_R);
      n_cmp++; if (bus.board !== 18'h00001) begin n_err++; $display("FAIL same_board got %h want 00001", bus.board); end
      n_cmp++; if (bus.player_address !== 4'd0) begin n_err++; $display("FAIL same_addr got %0d want 0", bus.player_address); end
      n_cmp++; if (bus.turn !== 1'b1) begin n_err++; $display("FAIL same_turn got %b want 1", bus.turn); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (bus.board !== 18'h0 || bus.turn !== 1'b0) begin n_err++; $display("FAIL async_reset got board %h turn %b want 0 0", bus.board, bus.turn); end
      @(negedge clk) rst = 1'b1;
      frames(1);
   endtask

   task automatic test_held_reset();
      set_btn(B_S);
      @(negedge clk) rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      frames(5);
      n_cmp++; if (bus.board !== 18'h0) begin n_err++; $display("FAIL held_silent got %h want 0", bus.board); end
      set_btn(5'b0);
      repeat (4) @(negedge clk);
      frames(4);
      press(B_S);
      n_cmp++; if (bus.board !== 18'h00001) begin n_err++; $display("FAIL held_repress got %h want 00001", bus.board); end
   endtask

`ifdef AUTO_REPEAT_EN
   task automatic test_repeat();
      do_reset();
      set_btn(B_R);
      repeat (4) @(negedge clk);
      frames(3);
      n_cmp++; if (bus.player_address !== 4'd1) begin n_err++; $display("FAIL rep_0 got %0d want 1", bus.player_address); end
      frames(14);
      n_cmp++; if (bus.player_address !== 4'd1) begin n_err++; $display("FAIL rep_14 got %0d want 1", bus.player_address); end
      frames(1);
      n_cmp++; if (bus.player_address !== 4'd2) begin n_err++; $display("FAIL rep_15 got %0d want 2", bus.player_address); end
      frames(15);
      n_cmp++; if (bus.player_address !== 4'd0) begin n_err++; $display("FAIL rep_30 got %0d want 0", bus.player_address); end
      set_btn(5'b0);
      repeat (4) @(negedge clk);
      frames(3);
   endtask
`endif

   initial begin
      #1ms;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      set_btn(5'b0);
      bus.vsync = 1'b1;
      test_reset();
      test_move();
      test_glitch();
      test_win();
      test_occupied();
      test_draw();
      test_same_tick();
      test_reset_mid();
      test_held_reset();
`ifdef AUTO_REPEAT_EN
      test_repeat();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
